// File: rtl/systolic_processor_vcounter_pkg.sv
// Shared sizing helpers for the output-stationary systolic multiplier.
// Result width, cycle-counter width and the terminal count all derive
// from the matrix dimension and operand width.
package systolic_processor_vcounter_pkg;

    // Accumulator width: full product width plus growth for SIZE summands
    function automatic int calc_o_bits(input int i_bits, input int size);
        return 2 * i_bits + $clog2(size);
    endfunction

    // Counter width large enough to hold the terminal count
    function automatic int calc_count_bits(input int size);
        return $clog2(3 * size - 1);
    endfunction

    // Count at which the last product has landed and everything freezes
    function automatic int calc_terminal_count(input int size);
        return 3 * size - 2;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// Single processing element: multiply-accumulate with operand forwarding.
// A moves right, B moves down; both hold when enable is low.
module systolic_pe
    import systolic_processor_vcounter_pkg::*;
#(
    parameter int I_BITS = 8,
    parameter int O_BITS = calc_o_bits(8, 8)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [I_BITS-1:0] a_in,
    input  logic [I_BITS-1:0] b_in,
    output logic [I_BITS-1:0] a_out,
    output logic [I_BITS-1:0] b_out,
    output logic [O_BITS-1:0] acc
);

    logic [2*I_BITS-1:0] product;

    assign product = a_in * b_in;

    // Accumulate the product and pass operands on; reset is active-low
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (enable) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + O_BITS'(product);
        end
    end

endmodule

// File: rtl/systolic_processor_vcounter.sv
// SIZE x SIZE output-stationary systolic matrix multiplier (C = A x B).
// A cycle counter stops accumulation once the full product has formed.
// Optional macro SYSTOLIC_DONE_EN adds an o_done completion flag.
module systolic_processor_vcounter
    import systolic_processor_vcounter_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int I_BITS = 8,
    parameter int O_BITS = calc_o_bits(I_BITS, SIZE)
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic [SIZE*I_BITS-1:0]      i_a_full,
    input  logic [SIZE*I_BITS-1:0]      i_b_full,
    output logic [SIZE*SIZE*O_BITS-1:0] o_c_full
`ifdef SYSTOLIC_DONE_EN
    ,
    output logic                        o_done
`endif
);

    localparam int CNT_BITS = calc_count_bits(SIZE);
    localparam logic [CNT_BITS-1:0] TERM_CNT = CNT_BITS'(calc_terminal_count(SIZE));

    logic [CNT_BITS-1:0] cycle_count;
    logic                enable;

    logic [I_BITS-1:0] a_fwd [SIZE][SIZE];
    logic [I_BITS-1:0] b_fwd [SIZE][SIZE];
    logic [O_BITS-1:0] acc   [SIZE][SIZE];

    // Operands that fall off the right and bottom edges go nowhere
    logic [2*SIZE*I_BITS-1:0] edge_spill;
    logic                     unused_edge;

    assign enable = (cycle_count < TERM_CNT);

    // Count edges since reset release, saturating at the terminal count
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cycle_count <= '0;
        end else if (enable) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end

`ifdef SYSTOLIC_DONE_EN
    assign o_done = (cycle_count == TERM_CNT);
`endif

    for (genvar r = 0; r < SIZE; r++) begin : g_row
        for (genvar c = 0; c < SIZE; c++) begin : g_col
            logic [I_BITS-1:0] a_in;
            logic [I_BITS-1:0] b_in;

            if (c == 0) begin : g_a_edge
                assign a_in = i_a_full[r*I_BITS +: I_BITS];
            end else begin : g_a_inner
                assign a_in = a_fwd[r][c-1];
            end

            if (r == 0) begin : g_b_edge
                assign b_in = i_b_full[c*I_BITS +: I_BITS];
            end else begin : g_b_inner
                assign b_in = b_fwd[r-1][c];
            end

            systolic_pe #(
                .I_BITS(I_BITS),
                .O_BITS(O_BITS)
            ) u_pe (
                .clock (i_clock),
                .reset (i_reset),
                .enable(enable),
                .a_in  (a_in),
                .b_in  (b_in),
                .a_out (a_fwd[r][c]),
                .b_out (b_fwd[r][c]),
                .acc   (acc[r][c])
            );

            assign o_c_full[(r*SIZE+c)*O_BITS +: O_BITS] = acc[r][c];
        end
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_spill
        assign edge_spill[i*I_BITS +: I_BITS]        = a_fwd[i][SIZE-1];
        assign edge_spill[(SIZE+i)*I_BITS +: I_BITS] = b_fwd[SIZE-1][i];
    end

    assign unused_edge = ^edge_spill;

endmodule

// File: tb/tb_systolic_processor_vcounter.sv
// Directed testbench for systolic_processor_vcounter at default sizing.
// Expected products come from a plain triple-loop matrix model.
// Define SYSTOLIC_DONE_EN to also check the o_done flag.
module tb_systolic_processor_vcounter;

    localparam int SIZE   = 8;
    localparam int I_BITS = 8;
    localparam int O_BITS = 19;
    localparam int LAST_T = 3 * SIZE - 3;

    logic                        i_clock = 1'b0;
    logic                        i_reset;
    logic [SIZE*I_BITS-1:0]      i_a_full;
    logic [SIZE*I_BITS-1:0]      i_b_full;
    logic [SIZE*SIZE*O_BITS-1:0] o_c_full;
`ifdef SYSTOLIC_DONE_EN
    logic                        o_done;
`endif

    int unsigned mat_a [SIZE][SIZE];
    int unsigned mat_b [SIZE][SIZE];
    int unsigned exp_c [SIZE][SIZE];

    int tests_run    = 0;
    int tests_failed = 0;

    systolic_processor_vcounter #(
        .SIZE  (SIZE),
        .I_BITS(I_BITS),
        .O_BITS(O_BITS)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_a_full(i_a_full),
        .i_b_full(i_b_full),
        .o_c_full(o_c_full)
`ifdef SYSTOLIC_DONE_EN
        ,
        .o_done  (o_done)
`endif
    );

    // Free-running clock
    always #5 i_clock = ~i_clock;

    task automatic checkOutput(input string tag, input longint unsigned observed,
                               input longint unsigned expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint unsigned get_c(input int r, input int c);
        return longint'(o_c_full[(r*SIZE+c)*O_BITS +: O_BITS]);
    endfunction

    function automatic void compute_expected();
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                exp_c[r][c] = 0;
                for (int k = 0; k < SIZE; k++) begin
                    exp_c[r][c] += mat_a[r][k] * mat_b[k][c];
                end
            end
        end
    endfunction

    function automatic void clear_mats();
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                mat_a[r][c] = 0;
                mat_b[r][c] = 0;
            end
        end
    endfunction

    // Skewed lanes for cycle t: A[r][t-r] on lane r, B[t-c][c] on lane c
    task automatic drive_lanes(input int t);
        int idx;
        for (int i = 0; i < SIZE; i++) begin
            idx = t - i;
            if (idx >= 0 && idx < SIZE) begin
                i_a_full[i*I_BITS +: I_BITS] = I_BITS'(mat_a[i][idx]);
                i_b_full[i*I_BITS +: I_BITS] = I_BITS'(mat_b[idx][i]);
            end else begin
                i_a_full[i*I_BITS +: I_BITS] = '0;
                i_b_full[i*I_BITS +: I_BITS] = '0;
            end
        end
    endtask

    // Starts and ends at a falling edge; releases reset just before t=0
    task automatic applyStimulus(input int first_t, input int last_t);
        for (int t = first_t; t <= last_t; t++) begin
            drive_lanes(t);
            if (t == 0) i_reset = 1'b1;
            @(negedge i_clock);
        end
    endtask

    task automatic drive_const(input logic [I_BITS-1:0] value, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            i_a_full = {SIZE{value}};
            i_b_full = {SIZE{value}};
            @(negedge i_clock);
        end
    endtask

    task automatic hold_reset(input int cycles);
        i_reset = 1'b0;
        for (int n = 0; n < cycles; n++) begin
            i_a_full = {$urandom(), $urandom()};
            i_b_full = {$urandom(), $urandom()};
            @(negedge i_clock);
        end
    endtask

    task automatic check_matrix(input string tag);
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                checkOutput($sformatf("%s C[%0d][%0d]", tag, r, c), get_c(r, c),
                            longint'(exp_c[r][c]));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        int nonzero;
        nonzero = 0;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                if (get_c(r, c) != 0) nonzero++;
            end
        end
        checkOutput({tag, " nonzero_elements"}, longint'(nonzero), 0);
    endtask

    function automatic void load_identity();
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                mat_a[r][c] = (r == c) ? 1 : 0;
                mat_b[r][c] = r * SIZE + c;
            end
        end
    endfunction

    initial begin
        i_reset  = 1'b0;
        i_a_full = '0;
        i_b_full = '0;
        @(negedge i_clock);

        // Reset hold with random lane activity
        hold_reset(5);
        check_all_zero("reset_hold");
        checkOutput("reset_hold count", longint'(dut.cycle_count), 0);
`ifdef SYSTOLIC_DONE_EN
        checkOutput("reset_hold done", longint'(o_done), 0);
`endif

        // Identity: C = B
        load_identity();
        compute_expected();
        applyStimulus(0, LAST_T);
        check_matrix("identity");
        checkOutput("identity count", longint'(dut.cycle_count), 22);
`ifdef SYSTOLIC_DONE_EN
        checkOutput("identity done", longint'(o_done), 1);
`endif
        drive_const(8'h00, 10);
        check_matrix("identity_hold");

        // Freeze: saturated inputs after completion must not disturb C
        drive_const(8'hFF, 20);
        check_matrix("freeze");
`ifdef SYSTOLIC_DONE_EN
        checkOutput("freeze done", longint'(o_done), 1);
`endif

        // Mid-operation reset then replay of the identity case
        hold_reset(2);
        applyStimulus(0, 9);
        hold_reset(2);
        check_all_zero("midreset");
`ifdef SYSTOLIC_DONE_EN
        checkOutput("midreset done", longint'(o_done), 0);
`endif
        applyStimulus(0, LAST_T);
        check_matrix("midreset_replay");

        // Worst case: all 255, every element 8*255*255
        hold_reset(2);
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                mat_a[r][c] = 255;
                mat_b[r][c] = 255;
            end
        end
        compute_expected();
        applyStimulus(0, LAST_T - 1);
`ifdef SYSTOLIC_DONE_EN
        checkOutput("worst early done", longint'(o_done), 0);
`endif
        checkOutput("worst early C[7][7]", get_c(7, 7), 7 * 255 * 255);
        applyStimulus(LAST_T, LAST_T);
        check_matrix("worst");
        checkOutput("worst C[0][0] const", get_c(0, 0), 520200);

        // Skew alignment: a single product lands in C[3][6]
        hold_reset(2);
        clear_mats();
        mat_a[3][5] = 7;
        mat_b[5][6] = 9;
        compute_expected();
        applyStimulus(0, LAST_T);
        check_matrix("skew");
        checkOutput("skew C[3][6] const", get_c(3, 6), 63);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
